// File: rtl/crc16_pkg.sv
// -----------------------------------------------------------------------------
// crc16_pkg
// Shared definitions for the CRC-16 stream engine: the generator polynomial,
// the engine FSM state type and two helpers that interpret a last-beat byte
// keep mask.
// -----------------------------------------------------------------------------
package crc16_pkg;

    // x^16 + x^15 + x^2 + 1, MSB-first, non-reflected.
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    // Widest keep mask the helpers accept (DATA_W up to 128 bits).
    localparam int KEEP_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_e;

    // Number of consecutive ones starting at bit keep_w-1 and walking down.
    // Bits at or above keep_w are ignored, so a narrower mask is passed
    // zero-extended.
    function automatic logic [4:0] count_leading_ones(input logic [KEEP_MAX-1:0] keep,
                                                      input int                  keep_w);
        logic [4:0] cnt;
        logic       run;
        cnt = '0;
        run = 1'b1;
        for (int i = KEEP_MAX - 1; i >= 0; i--) begin
            if (i < keep_w) begin
                if (run && keep[i]) begin
                    cnt = cnt + 5'd1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

    // True when the mask is a run of ones from the MSB followed only by zeros
    // (all-zero and all-one masks both qualify).
    function automatic logic keep_is_contiguous(input logic [KEEP_MAX-1:0] keep,
                                                input int                  keep_w);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = KEEP_MAX - 1; i >= 0; i--) begin
            if (i < keep_w) begin
                if (!keep[i]) begin
                    seen_zero = 1'b1;
                end else if (seen_zero) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/crc16_step.sv
// -----------------------------------------------------------------------------
// crc16_step
// Combinational CRC-16 update over the leading nbytes_i bytes of one beat.
// Byte 0 sits in data_i[DATA_W-1 -: 8] and is consumed first; each byte is fed
// MSB-first exactly as a bit-serial LFSR would see it.
//
// Ports:
//   crc_i    - CRC register before this beat
//   data_i   - beat data, byte 0 in the top byte
//   nbytes_i - number of leading bytes to fold in (0..DATA_W/8)
//   crc_o    - CRC register after this beat
// -----------------------------------------------------------------------------
module crc16_step
    import crc16_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [15:0]                     crc_i,
    input  logic [DATA_W-1:0]               data_i,
    input  logic [$clog2(DATA_W/8 + 1)-1:0] nbytes_i,
    output logic [15:0]                     crc_o
);

    localparam int KEEP_W = DATA_W / 8;

    logic [15:0] crc_acc;
    logic        fb;

    // NOTE: blocking assignments here are deliberate: crc_acc is a chain of
    // intermediate values unrolled across the loop, not a register.
    always_comb begin
        crc_acc = crc_i;
        fb      = 1'b0;
        for (int b = 0; b < KEEP_W; b++) begin
            if (b < int'(nbytes_i)) begin
                for (int j = 0; j < 8; j++) begin
                    fb      = crc_acc[15] ^ data_i[DATA_W - 1 - 8*b - j];
                    crc_acc = {crc_acc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
                end
            end
        end
    end

    assign crc_o = crc_acc;

endmodule

// File: rtl/crc16_stream_engine.sv
// -----------------------------------------------------------------------------
// crc16_stream_engine
// Multi-beat CRC-16 generator/checker. Beats arrive over a ready/valid input,
// are folded into a running CRC, and one result per packet is offered over a
// ready/valid output. The last beat may be partial (MSB-aligned byte keep) and
// can optionally be checked against a supplied CRC.
//
// Ports:
//   clk, reset_L         - clock, asynchronous active-low reset
//   abort                - synchronous packet abort, wins over any handshake
//   in_valid/in_ready    - input beat handshake (ready low only while a
//                          result is pending)
//   in_data, in_keep     - beat data (byte 0 on top) and last-beat byte keep
//   in_last              - marks the final beat of a packet
//   chk_en, chk_crc      - compare request and expected CRC, taken with the
//                          last beat
//   out_valid/out_ready  - result handshake
//   out_crc              - final CRC after XOROUT
//   out_match            - out_crc equals chk_crc and chk_en was set
//   out_err              - last-beat keep was not contiguous
// -----------------------------------------------------------------------------
module crc16_stream_engine
    import crc16_pkg::*;
#(
    parameter int          DATA_W = 64,
    parameter int          KEEP_W = DATA_W / 8,
    parameter logic [15:0] INIT   = 16'h0000,
    parameter logic [15:0] XOROUT = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic              chk_en,
    input  logic [15:0]       chk_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_crc,
    output logic              out_match,
    output logic              out_err
);

    localparam int NB_W = $clog2(KEEP_W + 1);

    state_e            state_q, state_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       out_crc_q, out_crc_d;
    logic              out_match_q, out_match_d;
    logic              out_err_q, out_err_d;

    logic              beat_fire;
    logic [NB_W-1:0]   nbytes;
    logic              keep_ok;
    logic [15:0]       crc_next;
    logic [15:0]       crc_final;

    assign in_ready  = (state_q != RESULT);
    assign beat_fire = in_valid && in_ready;

    // Non-last beats always carry a full word; in_keep only matters on the last.
    always_comb begin
        nbytes = NB_W'(KEEP_W);
        if (in_last) begin
            nbytes = NB_W'(count_leading_ones(KEEP_MAX'(in_keep), KEEP_W));
        end
    end

    assign keep_ok = keep_is_contiguous(KEEP_MAX'(in_keep), KEEP_W);

    crc16_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .crc_i    (crc_q),
        .data_i   (in_data),
        .nbytes_i (nbytes),
        .crc_o    (crc_next)
    );

    assign crc_final = crc_next ^ XOROUT;

    // NOTE: every signal driven here gets a default at the top so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_crc_d   = out_crc_q;
        out_match_d = out_match_q;
        out_err_d   = out_err_q;

        if (abort) begin
            state_d = IDLE;
            crc_d   = INIT;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_fire) begin
                        if (in_last) begin
                            state_d     = RESULT;
                            // The running CRC is no longer needed once the
                            // result is captured, so it is re-armed here and
                            // already holds INIT when IDLE is re-entered.
                            crc_d       = INIT;
                            out_crc_d   = crc_final;
                            out_match_d = chk_en && (crc_final == chk_crc);
                            out_err_d   = !keep_ok;
                        end else begin
                            state_d = ACCUM;
                            crc_d   = crc_next;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        crc_d   = INIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples its
    // _d value from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            out_crc_q   <= '0;
            out_match_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            out_crc_q   <= out_crc_d;
            out_match_q <= out_match_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = (state_q == RESULT);
    assign out_crc   = out_crc_q;
    assign out_match = out_match_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_crc16_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_crc16_stream_engine
// Four engine instances on two shared input buses:
//   bus A (8-bit beats):  a0 INIT=0000/XOROUT=0000, a1 INIT=FFFF/XOROUT=0000
//   bus B (64-bit beats): b0 INIT=0000/XOROUT=0000, b1 INIT=FFFF/XOROUT=0F0F
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_crc16_stream_engine;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [15:0] exp_crc0;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // bus A
    logic        a_abort, a_valid, a_last, a_chk_en, a_out_ready;
    logic [7:0]  a_data;
    logic [0:0]  a_keep;
    logic [15:0] a_chk_crc;
    logic        a0_in_ready, a0_out_valid, a0_out_match, a0_out_err;
    logic        a1_in_ready, a1_out_valid, a1_out_match, a1_out_err;
    logic [15:0] a0_out_crc, a1_out_crc;

    // bus B
    logic        b_abort, b_valid, b_last, b_chk_en, b_out_ready;
    logic [63:0] b_data;
    logic [7:0]  b_keep;
    logic [15:0] b_chk_crc;
    logic        b0_in_ready, b0_out_valid, b0_out_match, b0_out_err;
    logic        b1_in_ready, b1_out_valid, b1_out_match, b1_out_err;
    logic [15:0] b0_out_crc, b1_out_crc;

    crc16_stream_engine #(.DATA_W(8), .INIT(16'h0000), .XOROUT(16'h0000)) u_a0 (
        .clk(clk), .reset_L(rst_n), .abort(a_abort), .in_valid(a_valid), .in_ready(a0_in_ready),
        .in_data(a_data), .in_keep(a_keep), .in_last(a_last), .chk_en(a_chk_en), .chk_crc(a_chk_crc),
        .out_valid(a0_out_valid), .out_ready(a_out_ready), .out_crc(a0_out_crc),
        .out_match(a0_out_match), .out_err(a0_out_err));

    crc16_stream_engine #(.DATA_W(8), .INIT(16'hFFFF), .XOROUT(16'h0000)) u_a1 (
        .clk(clk), .reset_L(rst_n), .abort(a_abort), .in_valid(a_valid), .in_ready(a1_in_ready),
        .in_data(a_data), .in_keep(a_keep), .in_last(a_last), .chk_en(a_chk_en), .chk_crc(a_chk_crc),
        .out_valid(a1_out_valid), .out_ready(a_out_ready), .out_crc(a1_out_crc),
        .out_match(a1_out_match), .out_err(a1_out_err));

    crc16_stream_engine #(.DATA_W(64), .INIT(16'h0000), .XOROUT(16'h0000)) u_b0 (
        .clk(clk), .reset_L(rst_n), .abort(b_abort), .in_valid(b_valid), .in_ready(b0_in_ready),
        .in_data(b_data), .in_keep(b_keep), .in_last(b_last), .chk_en(b_chk_en), .chk_crc(b_chk_crc),
        .out_valid(b0_out_valid), .out_ready(b_out_ready), .out_crc(b0_out_crc),
        .out_match(b0_out_match), .out_err(b0_out_err));

    crc16_stream_engine #(.DATA_W(64), .INIT(16'hFFFF), .XOROUT(16'h0F0F)) u_b1 (
        .clk(clk), .reset_L(rst_n), .abort(b_abort), .in_valid(b_valid), .in_ready(b1_in_ready),
        .in_data(b_data), .in_keep(b_keep), .in_last(b_last), .chk_en(b_chk_en), .chk_crc(b_chk_crc),
        .out_valid(b1_out_valid), .out_ready(b_out_ready), .out_crc(b1_out_crc),
        .out_match(b1_out_match), .out_err(b1_out_err));

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lead_ones(input logic [7:0] k);
        int n = 0;
        while (n < 8 && k[7-n]) n++;
        return n;
    endfunction

    // Bit-serial reference CRC (no XOROUT).
    function automatic logic [15:0] ref_crc(input logic [15:0] init, input byte_q_t q);
        logic [15:0] c;
        c = init;
        foreach (q[i]) begin
            for (int j = 7; j >= 0; j--) begin
                if (c[15] ^ q[i][j]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else                 c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic byte_q_t beat_bytes(input logic [63:0] d, input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(d[63-8*i -: 8]);
        return q;
    endfunction

    // All tasks start and end 1 unit after a rising edge.
    task automatic a_beat(input logic [7:0] d, input logic last, input logic ce, input logic [15:0] cc);
        int guard = 0;
        a_valid = 1'b1; a_data = d; a_keep = 1'b1; a_last = last; a_chk_en = ce; a_chk_crc = cc;
        while (!a0_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        if (!a0_in_ready) check("a_ready_timeout", 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic a_packet(input logic ce, input logic [15:0] cc);
        for (int i = 0; i < 9; i++) a_beat(8'h31 + 8'(i), i == 8, ce, cc);
    endtask

    task automatic a_take(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic m0, input logic m1);
        check({tag, "_valid"}, a0_out_valid, 1);
        check({tag, "_crc0"},  a0_out_crc, e0);
        check({tag, "_crc1"},  a1_out_crc, e1);
        check({tag, "_match0"}, a0_out_match, m0);
        check({tag, "_match1"}, a1_out_match, m1);
        a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
        check({tag, "_drop"}, a0_out_valid, 0);
    endtask

    task automatic b_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                          input logic ce, input logic [15:0] cc);
        int guard = 0;
        b_valid = 1'b1; b_data = d; b_keep = k; b_last = last; b_chk_en = ce; b_chk_crc = cc;
        while (!b0_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        if (!b0_in_ready) check("b_ready_timeout", 0, 1);
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic b_take(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic e_err, input logic m0);
        check({tag, "_valid"}, b0_out_valid, 1);
        check({tag, "_crc0"},  b0_out_crc, e0);
        check({tag, "_crc1"},  b1_out_crc, e1);
        check({tag, "_err0"},  b0_out_err, e_err);
        check({tag, "_err1"},  b1_out_err, e_err);
        check({tag, "_match0"}, b0_out_match, m0);
        b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
        check({tag, "_drop"}, b0_out_valid, 0);
    endtask

    task automatic b_check_packet(input string tag, input logic ce, input logic [15:0] cc);
        b_beat(64'h3132333435363738, 8'hFF, 1'b0, 1'b0, 16'h0);
        b_beat(64'h39A5A5A5A5A5A5A5, 8'h80, 1'b1, ce, cc);
    endtask

    // ------------------------------------------------------------------ test
    vec_t vecs[9];

    initial begin
        a_abort = 0; a_valid = 0; a_last = 0; a_chk_en = 0; a_out_ready = 0;
        a_data = '0; a_keep = '0; a_chk_crc = '0;
        b_abort = 0; b_valid = 0; b_last = 0; b_chk_en = 0; b_out_ready = 0;
        b_data = '0; b_keep = '0; b_chk_crc = '0;

        vecs[0] = '{64'h0000000000000001, 8'hFF, 16'h8005, 1'b0};
        vecs[1] = '{64'h0000000000000080, 8'hFF, 16'h8303, 1'b0};
        vecs[2] = '{64'h0000000000000081, 8'hFF, 16'h0306, 1'b0};
        vecs[3] = '{64'h01A5A5A5A5A5A5A5, 8'h80, 16'h8005, 1'b0};
        vecs[4] = '{64'h0100A5A5A5A5A5A5, 8'hC0, 16'h8603, 1'b0};
        vecs[5] = '{64'h80C3112233445566, 8'hA0, 16'h8303, 1'b1};
        vecs[6] = '{64'h123456789ABCDEF0, 8'h00, 16'h0000, 1'b0};
        vecs[7] = '{64'hFFFFFFFFFFFFFFFF, 8'h40, 16'h0000, 1'b1};
        vecs[8] = '{64'h0000000000000000, 8'hFF, 16'h0000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_a", a0_out_valid, 0);
        check("rst_valid_b", b0_out_valid, 0);
        check("rst_crc_b1",  b1_out_crc, 0);
        check("rst_match_b", b0_out_match, 0);
        check("rst_err_b",   b0_out_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_a", a0_in_ready, 1);
        check("rst_ready_b", b0_in_ready, 1);

        // 8-bit "123456789": BUYPASS FEE8 and CMS AEE7, plus compare modes
        a_packet(1'b1, 16'hAEE7);
        a_take("a_cms_ok", 16'hFEE8, 16'hAEE7, 1'b0, 1'b1);
        a_packet(1'b1, 16'hAEE6);
        a_take("a_cms_bad", 16'hFEE8, 16'hAEE7, 1'b0, 1'b0);
        a_packet(1'b0, 16'hAEE7);
        a_take("a_chk_off", 16'hFEE8, 16'hAEE7, 1'b0, 1'b0);
        a_packet(1'b1, 16'hFEE8);
        a_take("a_buy_ok", 16'hFEE8, 16'hAEE7, 1'b1, 1'b0);

        // Table of single-beat 64-bit packets
        for (int i = 0; i < 9; i++) begin
            byte_q_t q;
            logic [15:0] e1;
            q  = beat_bytes(vecs[i].data, lead_ones(vecs[i].keep));
            e1 = ref_crc(16'hFFFF, q) ^ 16'h0F0F;
            b_beat(vecs[i].data, vecs[i].keep, 1'b1, 1'b0, 16'h0);
            b_take($sformatf("vec%0d", i), vecs[i].exp_crc0, e1, vecs[i].exp_err, 1'b0);
        end

        // Two-beat 64-bit packet held for 5 cycles with out_ready low
        b_check_packet("hold", 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", b0_out_valid, 1);
            check("hold_crc0",  b0_out_crc, 16'hFEE8);
            check("hold_crc1",  b1_out_crc, 16'hA1E8);
            check("hold_ready", b0_in_ready, 0);
            @(posedge clk); #1;
        end
        b_take("hold_rel", 16'hFEE8, 16'hA1E8, 1'b0, 1'b0);

        // Abort on the second of three beats; the third then forms its own packet
        b_beat(64'h3132333435363738, 8'hFF, 1'b0, 1'b0, 16'h0);
        b_valid = 1'b1; b_data = 64'h3132333435363738; b_keep = 8'hFF; b_last = 1'b0; b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0; b_valid = 1'b0;
        check("abort_ready", b0_in_ready, 1);
        check("abort_valid", b0_out_valid, 0);
        begin
            byte_q_t q;
            q = beat_bytes(64'h3900000000000000, 1);
            b_beat(64'h3900000000000000, 8'h80, 1'b1, 1'b0, 16'h0);
            b_take("abort_tail", ref_crc(16'h0000, q), ref_crc(16'hFFFF, q) ^ 16'h0F0F, 1'b0, 1'b0);
        end
        // Abort on a last beat yields no result at all
        b_beat(64'h3132333435363738, 8'hFF, 1'b0, 1'b0, 16'h0);
        b_valid = 1'b1; b_data = 64'h39A5A5A5A5A5A5A5; b_keep = 8'h80; b_last = 1'b1; b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0; b_valid = 1'b0; b_last = 1'b0;
        check("abort_last_v0", b0_out_valid, 0);
        @(posedge clk); #1;
        check("abort_last_v1", b0_out_valid, 0);
        b_check_packet("post_abort", 1'b0, 16'h0);
        b_take("post_abort", 16'hFEE8, 16'hA1E8, 1'b0, 1'b0);

        // Asynchronous reset with a result pending, then mid-packet
        b_check_packet("pre_rst", 1'b1, 16'hFEE8);
        check("pre_rst_match", b0_out_match, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", b0_out_valid, 0);
        check("arst_crc0",  b0_out_crc, 0);
        check("arst_crc1",  b1_out_crc, 0);
        check("arst_match", b0_out_match, 0);
        check("arst_err",   b0_out_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_beat(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 1'b0, 16'h0);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_check_packet("post_rst", 1'b0, 16'h0);
        b_take("post_rst", 16'hFEE8, 16'hA1E8, 1'b0, 1'b0);

        // 200 random back-to-back packets, valid and ready held high
        begin
            logic [15:0] exp0_q[$], exp1_q[$];
            logic        experr_q[$], expm0_q[$], expm1_q[$];
            int          total_beats = 0;
            int          got = 0, cyc = 0, bubbles = 0, last_cyc = 0;
            b_out_ready = 1'b1;
            fork
                begin : driver
                    byte_q_t q;
                    for (int p = 0; p < 200; p++) begin
                        int nb;
                        nb = $urandom_range(1, 4);
                        q.delete();
                        for (int k = 0; k < nb; k++) begin
                            logic [63:0] d;
                            logic [7:0]  kp;
                            logic        lst, ce;
                            logic [15:0] cc, e0, e1;
                            d   = {$urandom, $urandom};
                            lst = (k == nb - 1);
                            kp  = lst ? 8'($urandom) : 8'hFF;
                            q   = {q, beat_bytes(d, lst ? lead_ones(kp) : 8)};
                            ce  = 1'b0;
                            cc  = 16'h0;
                            if (lst) begin
                                e0 = ref_crc(16'h0000, q);
                                e1 = ref_crc(16'hFFFF, q) ^ 16'h0F0F;
                                ce = 1'($urandom);
                                cc = $urandom_range(0, 1) ? e0 : (e0 ^ 16'h0100);
                                exp0_q.push_back(e0);
                                exp1_q.push_back(e1);
                                experr_q.push_back(kp != (8'hFF << (8 - lead_ones(kp))));
                                expm0_q.push_back(ce && (cc == e0));
                                expm1_q.push_back(ce && (cc == e1));
                            end
                            total_beats++;
                            b_valid = 1'b1;
                            b_beat(d, kp, lst, ce, cc);
                            b_valid = 1'b1;
                        end
                    end
                    b_valid = 1'b0;
                end
                begin : collector
                    while (got < 200 && cyc < 3000) begin
                        @(posedge clk); #1;
                        cyc++;
                        if (!b0_in_ready) bubbles++;
                        if (b0_out_valid) begin
                            if (exp0_q.size() == 0) begin
                                check("rnd_spurious", 1, 0);
                            end else begin
                                check("rnd_crc0",   b0_out_crc,   exp0_q.pop_front());
                                check("rnd_crc1",   b1_out_crc,   exp1_q.pop_front());
                                check("rnd_err",    b0_out_err,   experr_q.pop_front());
                                check("rnd_match0", b0_out_match, expm0_q.pop_front());
                                check("rnd_match1", b1_out_match, expm1_q.pop_front());
                            end
                            got++;
                            last_cyc = cyc;
                        end
                    end
                end
            join
            b_out_ready = 1'b0;
            check("rnd_count",   got, 200);
            check("rnd_bubbles", bubbles, 200);
            check("rnd_cycles",  last_cyc, total_beats + 199);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_stream_engine.md
Name: crc16_stream_engine

Overview:
Sequential CRC-16 generator/checker for multi-beat packet streams, polynomial x^16+x^15+x^2+1 (0x8005), MSB-first, non-reflected. Succeeds the fixed 64-bit combinational CRC step:
- parametrised data width
- ready/valid input and output handshakes
- per-packet accumulation across beats
- partial last beat via byte keep
- configurable init and final XOR
- check mode against a supplied expected CRC

Sits between the transaction packet builder/parser and the endpoint link layer.

Parameters:
DATA_W, 64, input beat width in bits; multiple of 8, range 8..128
KEEP_W, DATA_W/8, byte-keep width (derived; do not override)
INIT, 16'h0000, CRC register value at start of each packet
XOROUT, 16'h0000, value XORed into the final CRC before output

Ports:
clk  in  1  clock, all state on rising edge
reset_L  in  1  asynchronous active-low reset
abort  in  1  synchronous packet abort; returns to IDLE
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts beat
in_data  in  DATA_W  beat data; bits [DATA_W-1:DATA_W-8] are byte 0, processed first
in_keep  in  KEEP_W  valid bytes on last beat; MSB-aligned contiguous ones; ignored unless in_last
in_last  in  1  final beat of packet
chk_en  in  1  sampled with the last beat; 1 = compare against chk_crc
chk_crc  in  16  expected CRC, sampled with the last beat
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_crc  out  16  final CRC (after XOROUT)
out_match  out  1  out_crc == chk_crc (0 when chk_en was 0)
out_err  out  1  non-contiguous in_keep seen on the last beat

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=IDLE, crc_reg=INIT
  - out_valid=0, out_crc=0, out_match=0, out_err=0
  - in_ready=1 after reset release
- States:
  - IDLE: no packet in progress. A beat is accepted when in_valid && in_ready. Accepted non-last beat → ACCUM. Accepted last beat → RESULT.
  - ACCUM: accepted beats update crc_reg. Accepted last beat → RESULT.
  - RESULT: out_valid=1. out_valid && out_ready → IDLE.
- in_ready = (state != RESULT). No input is accepted while a result is pending. Back-to-back packets: first beat of the next packet accepted in the cycle after the handshake.
- CRC update per accepted beat: crc_next = step(crc_reg, data, nbytes).
  - Non-last beat: nbytes=KEEP_W.
  - Last beat: nbytes = count of leading ones in in_keep.
  - step processes nbytes bytes MSB-first, bit-serial-equivalent: fb = crc[15]^d; crc = {crc[14:0],0} ^ (fb ? 16'h8005 : 0).
  - Purely combinational within one cycle.
- Latency: out_valid asserts the cycle after the last beat is accepted. out_crc = crc_next ^ XOROUT, registered.
- First beat of a packet seeds from INIT. crc_reg reloads INIT on entry to IDLE.
- Last beat with in_keep all zero: CRC of the prior beats only. Single-beat packet with keep 0 → out_crc = INIT^XOROUT.
- Non-contiguous in_keep on a last beat: use the leading-ones count, set out_err=1 for that result.
- out_match = chk_en_s && (out_crc == chk_crc_s); chk_en and chk_crc are sampled on the last-beat handshake.
- out_* hold stable while out_valid && !out_ready.
- abort has priority over every handshake in the same cycle:
  - next state IDLE, crc_reg=INIT, out_valid=0
  - the beat presented that cycle is discarded
- Reset mid-packet: all partial state is lost. The next accepted beat starts a new packet.

Decomposition:
- Package crc16_pkg: CRC16_POLY=16'h8005, state enum {IDLE, ACCUM, RESULT}, function count_leading_ones(keep).
- Sub-module crc16_step (combinational, parameter DATA_W): inputs crc, data, nbytes; output next CRC. This is the only combinational CRC logic.
- The top holds the FSM, registers and handshakes.

Test Plan:
- DATA_W=8, INIT=0, XOROUT=0, nine beats "123456789" (0x31..0x39), last on 0x39 → out_crc=16'hFEE8, out_valid one cycle after last.
- DATA_W=8, INIT=16'hFFFF, same stream → out_crc=16'hAEE7. With chk_en=1, chk_crc=16'hAEE7 → out_match=1; with chk_crc=16'hAEE6 → out_match=0.
- DATA_W=64, INIT=0, beat0=64'h3132333435363738 (not last), beat1=64'h39xxxxxxxxxxxxxx last with keep=8'h80 → out_crc=16'hFEE8. Hold out_ready=0 for 5 cycles → out_* stable and in_ready=0 throughout.
- DATA_W=64, single last beat, keep=8'h00 → out_crc=INIT^XOROUT. Keep=8'hA0 → out_err=1 and CRC computed over byte 0 only.
- DATA_W=64: abort asserted on the cycle of the second of three beats → next state IDLE, no out_valid. Then resend "123456789" → 16'hFEE8. Separately, reset_L pulsed low mid-packet → all outputs zero asynchronously, next packet correct.
- Back-to-back packets with out_ready tied 1 and in_valid tied 1 → one bubble per packet, each result equal to the software reference model over 200 random packets of random length and keep.
